// File: rtl/bp_cfg_boot_pkg.sv
// Shared definitions for the boot-time config sequencer: register map,
// sequencer state and per-core write step encodings.
package bp_cfg_boot_pkg;

   localparam int unsigned cfg_reg_addr_width_gp = 16;
   localparam int unsigned num_steps_gp          = 6;

   localparam logic [cfg_reg_addr_width_gp-1:0] cfg_addr_freeze_gp      = 16'h0001;
   localparam logic [cfg_reg_addr_width_gp-1:0] cfg_addr_core_id_gp     = 16'h0002;
   localparam logic [cfg_reg_addr_width_gp-1:0] cfg_addr_icache_mode_gp = 16'h0003;
   localparam logic [cfg_reg_addr_width_gp-1:0] cfg_addr_dcache_mode_gp = 16'h0004;
   localparam logic [cfg_reg_addr_width_gp-1:0] cfg_addr_cce_mode_gp    = 16'h0005;
   localparam logic [cfg_reg_addr_width_gp-1:0] cfg_addr_npc_gp         = 16'h0006;

   typedef enum logic [2:0] {
      e_boot_idle,
      e_boot_config,
      e_boot_unfreeze,
      e_boot_drain,
      e_boot_done
   } bp_cfg_boot_state_e;

   typedef enum logic [2:0] {
      e_step_freeze,
      e_step_core_id,
      e_step_icache_mode,
      e_step_dcache_mode,
      e_step_cce_mode,
      e_step_npc
   } bp_cfg_boot_step_e;

   // Register address written by each configuration step
   function automatic logic [cfg_reg_addr_width_gp-1:0] step_addr(input bp_cfg_boot_step_e step);
      logic [cfg_reg_addr_width_gp-1:0] addr;
      unique case (step)
         e_step_freeze:      addr = cfg_addr_freeze_gp;
         e_step_core_id:     addr = cfg_addr_core_id_gp;
         e_step_icache_mode: addr = cfg_addr_icache_mode_gp;
         e_step_dcache_mode: addr = cfg_addr_dcache_mode_gp;
         e_step_cce_mode:    addr = cfg_addr_cce_mode_gp;
         default:            addr = cfg_addr_npc_gp;
      endcase
      return addr;
   endfunction

endpackage

// File: rtl/bsg_counter_up_down.sv
// Up/down counter tracking in-flight config writes; caller guarantees no
// underflow and no overflow past max_val_p.
module bsg_counter_up_down #(
   parameter int unsigned max_val_p  = 4,
   parameter int unsigned init_val_p = 0,
   parameter int unsigned width_p    = $clog2(max_val_p + 1)
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               up_i,
   input  logic               down_i,
   output logic [width_p-1:0] count_o
);

   always_ff @(posedge clk_i) begin
      if (reset_i)
         count_o <= width_p'(init_val_p);
      else
         count_o <= count_o + width_p'(up_i) - width_p'(down_i);
   end

endmodule

// File: rtl/bp_cfg_boot_sequencer.sv
// Issues the per-core config write sequence (freeze, id, modes, boot PC),
// then unfreezes every core and waits for all write acks.
module bp_cfg_boot_sequencer
   import bp_cfg_boot_pkg::*;
#(
   parameter int unsigned num_core_p        = 4,
   parameter int unsigned vaddr_width_p     = 39,
   parameter int unsigned cfg_addr_width_p  = 16,
   parameter int unsigned cfg_data_width_p  = 64,
   parameter int unsigned max_outstanding_p = 4,
   localparam int unsigned core_width_lp    = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        start_i,
   input  logic [vaddr_width_p-1:0]    boot_pc_i,
   input  logic [1:0]                  cache_mode_i,
   input  logic                        cce_mode_i,
   output logic                        cfg_v_o,
   input  logic                        cfg_ready_i,
   output logic [core_width_lp-1:0]    cfg_dst_o,
   output logic [cfg_addr_width_p-1:0] cfg_addr_o,
   output logic [cfg_data_width_p-1:0] cfg_data_o,
   input  logic                        cfg_ack_i,
   output logic                        busy_o,
   output logic                        done_o,
   output logic                        err_o
);

   localparam int unsigned cred_width_lp = $clog2(max_outstanding_p + 1);
   localparam logic [core_width_lp-1:0] last_core_lp = core_width_lp'(num_core_p - 1);
   localparam logic [cred_width_lp-1:0] max_cred_lp  = cred_width_lp'(max_outstanding_p);

   bp_cfg_boot_state_e state_r, state_n;
   bp_cfg_boot_step_e  step_r, step_n;
   logic [core_width_lp-1:0]    core_r, core_n;
   logic [vaddr_width_p-1:0]    pc_r, pc_n;
   logic [1:0]                  cache_mode_r, cache_mode_n;
   logic                        cce_mode_r, cce_mode_n;
   logic                        v_n, busy_n, done_n, err_n;
   logic [core_width_lp-1:0]    dst_n;
   logic [cfg_addr_width_p-1:0] addr_n;
   logic [cfg_data_width_p-1:0] data_n;

   logic                     accept, ack_ok, ack_err, issue;
   logic [cred_width_lp-1:0] cred, cred_n;

   assign accept  = cfg_v_o & cfg_ready_i;
   assign ack_ok  = cfg_ack_i & (cred != '0);
   assign ack_err = cfg_ack_i & (cred == '0);
   assign cred_n  = cred + cred_width_lp'(accept) - cred_width_lp'(ack_ok);

   bsg_counter_up_down #(
      .max_val_p (max_outstanding_p),
      .init_val_p(0),
      .width_p   (cred_width_lp)
   ) credit_cnt (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .up_i   (accept),
      .down_i (ack_ok),
      .count_o(cred)
   );

   // Write data for a configuration step
   function automatic logic [cfg_data_width_p-1:0] step_data(
      input bp_cfg_boot_step_e        step,
      input logic [core_width_lp-1:0] core,
      input logic [vaddr_width_p-1:0] pc,
      input logic [1:0]               cache_mode,
      input logic                     cce_mode
   );
      logic [cfg_data_width_p-1:0] data;
      unique case (step)
         e_step_freeze:      data = cfg_data_width_p'(1'b1);
         e_step_core_id:     data = cfg_data_width_p'(core);
         e_step_icache_mode: data = cfg_data_width_p'(cache_mode);
         e_step_dcache_mode: data = cfg_data_width_p'(cache_mode);
         e_step_cce_mode:    data = cfg_data_width_p'(cce_mode);
         default:            data = cfg_data_width_p'(pc);
      endcase
      return data;
   endfunction

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r      <= e_boot_idle;
         step_r       <= e_step_freeze;
         core_r       <= '0;
         pc_r         <= '0;
         cache_mode_r <= '0;
         cce_mode_r   <= 1'b0;
         cfg_v_o      <= 1'b0;
         cfg_dst_o    <= '0;
         cfg_addr_o   <= '0;
         cfg_data_o   <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
      end else begin
         state_r      <= state_n;
         step_r       <= step_n;
         core_r       <= core_n;
         pc_r         <= pc_n;
         cache_mode_r <= cache_mode_n;
         cce_mode_r   <= cce_mode_n;
         cfg_v_o      <= v_n;
         cfg_dst_o    <= dst_n;
         cfg_addr_o   <= addr_n;
         cfg_data_o   <= data_n;
         busy_o       <= busy_n;
         done_o       <= done_n;
         err_o        <= err_n;
      end
   end

   // Next state, sequence pointer and registered write payload
   always_comb begin
      state_n      = state_r;
      step_n       = step_r;
      core_n       = core_r;
      pc_n         = pc_r;
      cache_mode_n = cache_mode_r;
      cce_mode_n   = cce_mode_r;
      v_n          = cfg_v_o & ~accept;
      dst_n        = cfg_dst_o;
      addr_n       = cfg_addr_o;
      data_n       = cfg_data_o;
      err_n        = err_o | ack_err;

      unique case (state_r)
         e_boot_idle, e_boot_done: begin
            if (start_i) begin
               state_n      = e_boot_config;
               step_n       = e_step_freeze;
               core_n       = '0;
               pc_n         = boot_pc_i;
               cache_mode_n = cache_mode_i;
               cce_mode_n   = cce_mode_i;
            end
         end
         e_boot_config: begin
            if (accept) begin
               if (step_r == e_step_npc) begin
                  step_n = e_step_freeze;
                  if (core_r == last_core_lp) begin
                     core_n  = '0;
                     state_n = e_boot_unfreeze;
                  end else begin
                     core_n = core_r + core_width_lp'(1);
                  end
               end else begin
                  step_n = bp_cfg_boot_step_e'(step_r + 3'd1);
               end
            end
         end
         e_boot_unfreeze: begin
            if (accept) begin
               if (core_r == last_core_lp) begin
                  core_n  = '0;
                  state_n = e_boot_drain;
               end else begin
                  core_n = core_r + core_width_lp'(1);
               end
            end
         end
         e_boot_drain: begin
            if (cred == '0)
               state_n = e_boot_done;
         end
         default: state_n = e_boot_idle;
      endcase

      // Present the next write only when the link slot is free and a credit remains
      issue = (state_n == e_boot_config) || (state_n == e_boot_unfreeze);
      if (issue && (!cfg_v_o || accept) && (cred_n < max_cred_lp)) begin
         v_n   = 1'b1;
         dst_n = core_n;
         if (state_n == e_boot_unfreeze) begin
            addr_n = cfg_addr_width_p'(cfg_addr_freeze_gp);
            data_n = '0;
         end else begin
            addr_n = cfg_addr_width_p'(step_addr(step_n));
            data_n = step_data(step_n, core_n, pc_n, cache_mode_n, cce_mode_n);
         end
      end

      busy_n = (state_n == e_boot_config) || (state_n == e_boot_unfreeze)
            || (state_n == e_boot_drain);
      done_n = (state_n == e_boot_done);
   end

endmodule
